// File: rtl/fwrisc_shift_seq.sv
// Multi-cycle shift sequencer: iterates the single-bit ALU shift shamt times,
// feeding alu_out back as op_a, and returns the result on a valid/ready response.
module fwrisc_shift_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter logic [7:0]  OP_SLL  = 8'd3,
  parameter logic [7:0]  OP_SRL  = 8'd4,
  parameter logic [7:0]  OP_SRA  = 8'd5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_kind,
  input  logic [DATA_W-1:0]  req_val,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               busy,
  output logic [DATA_W-1:0]  alu_op_a,
  output logic [DATA_W-1:0]  alu_op_b,
  output logic [7:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  acc, acc_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic [1:0]         kind, kind_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      kind  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      kind  <= kind_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    kind_nxt  = kind;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          acc_nxt  = req_val;
          cnt_nxt  = req_shamt;
          kind_nxt = req_kind;
          // Zero shift and the reserved kind skip the ALU entirely.
          if (req_shamt == '0 || req_kind == 2'b11) state_nxt = DONE;
          else                                      state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = alu_out;
        cnt_nxt = cnt - 1'b1;
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unique case (kind)
      2'b01:   alu_op = OP_SRL;
      2'b10:   alu_op = OP_SRA;
      default: alu_op = OP_SLL;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_data  = acc;
  assign alu_op_a  = acc;
  assign alu_op_b  = '0;

endmodule

// File: tb/tb_fwrisc_shift_seq.sv
// Directed bench for fwrisc_shift_seq with a behavioural single-bit shift ALU.
module tb_fwrisc_shift_seq;

  localparam logic [7:0] OP_SLL = 8'd3;
  localparam logic [7:0] OP_SRL = 8'd4;
  localparam logic [7:0] OP_SRA = 8'd5;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [31:0] req_val;
  logic [4:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [7:0]  alu_op;
  logic [31:0] alu_out;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fwrisc_shift_seq #(
    .DATA_W (32),
    .SHAMT_W(5),
    .OP_SLL (OP_SLL),
    .OP_SRL (OP_SRL),
    .OP_SRA (OP_SRA)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_kind (req_kind),
    .req_val  (req_val),
    .req_shamt(req_shamt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy),
    .alu_op_a (alu_op_a),
    .alu_op_b (alu_op_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out)
  );

  // Single-bit shift ALU model
  always_comb begin
    case (alu_op)
      OP_SLL:  alu_out = alu_op_a << 1;
      OP_SRL:  alu_out = alu_op_a >> 1;
      OP_SRA:  alu_out = $unsigned($signed(alu_op_a) >>> 1);
      default: alu_out = alu_op_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] op_for(input logic [1:0] k);
    case (k)
      2'b01:   return OP_SRL;
      2'b10:   return OP_SRA;
      default: return OP_SLL;
    endcase
  endfunction

  // Issues one request and waits for its response; leaves the bench in DONE.
  task automatic issue(input string tag, input logic [1:0] k, input logic [31:0] v,
                       input logic [4:0] s, input logic [31:0] exp, input int exp_lat,
                       input int exp_ops);
    int lat;
    int ops;
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_kind  = k;
    req_val   = v;
    req_shamt = s;
    tick();
    req_valid = 1'b0;
    req_val   = 32'h5A5A_5A5A;
    req_shamt = 5'd1;
    req_kind  = 2'b00;
    lat = 1;
    ops = 0;
    while (!rsp_valid && lat < 100) begin
      if (busy) begin
        if (ops == 0) check({tag, ".alu_op"}, {24'd0, alu_op}, {24'd0, op_for(k)});
        ops++;
      end
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".alu_ops"}, ops, exp_ops);
    check({tag, ".rsp_data"}, rsp_data, exp);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'b00;
    req_val   = '0;
    req_shamt = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.busy",      {31'd0, busy},      32'd0);
    check("rst.rsp_data",  rsp_data,           32'd0);
    check("rst.alu_op_a",  alu_op_a,           32'd0);
    check("rst.alu_op_b",  alu_op_b,           32'd0);
    check("rst.alu_op",    {24'd0, alu_op},    {24'd0, OP_SLL});

    // 1: maximum shift amount
    issue("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 31);
    tick();
    // 2: arithmetic vs logical right shift
    issue("sra4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 5, 4);
    tick();
    issue("srl4", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 4);
    tick();
    // 3: zero shift and reserved kind bypass the ALU
    issue("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 0);
    tick();
    issue("kind3", 2'b11, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF, 1, 0);
    tick();
    check("kind3.idle", {31'd0, req_ready}, 32'd1);

    // 4: response back-pressure
    rsp_ready = 1'b0;
    issue("srl8", 2'b01, 32'h0000_F000, 5'd8, 32'h0000_00F0, 9, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.rsp_data",  rsp_data,           32'h0000_00F0);
      check("hold.req_ready", {31'd0, req_ready}, 32'd0);
      check("hold.busy",      {31'd0, busy},      32'd1);
      check("hold.rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check("release.req_ready", {31'd0, req_ready}, 32'd1);
    check("release.rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // 5: back-to-back with req_valid held; second accept waits for handshake
    req_valid = 1'b1;
    req_kind  = 2'b00;
    req_val   = 32'h0000_0001;
    req_shamt = 5'd2;
    tick();
    req_kind  = 2'b01;
    req_val   = 32'h0000_0100;
    req_shamt = 5'd3;
    n = 0;
    while (!req_ready && n < 20) begin
      if (rsp_valid) check("b2b.first_data", rsp_data, 32'h0000_0004);
      tick();
      n++;
    end
    check("b2b.interval", n + 1, 32'd4);
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("b2b.second_lat",  n,        32'd4);
    check("b2b.second_data", rsp_data, 32'h0000_0020);
    tick();

    // 6: asynchronous reset mid-shift
    req_valid = 1'b1;
    req_kind  = 2'b00;
    req_val   = 32'h0000_00FF;
    req_shamt = 5'd5;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort.busy",      {31'd0, busy},      32'd0);
    check("abort.alu_op_a",  alu_op_a,           32'd0);
    check("abort.rsp_data",  rsp_data,           32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("abort.rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    issue("post_rst", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 3, 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
